// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline stall-control definitions: FSM encodings, the
// per-cycle control bundle and helpers used by the controller, the
// pipeid integration and the bench.
package pipe_stall_ctrl_pkg;

    // Controller state encodings; code 3 is unused and behaves as ERROR.
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_ERROR   = 2'd2;

    // Pipeline control outputs produced each cycle.
    typedef struct packed {
        logic wpcir;
        logic dbubble;
        logic freeze;
        logic flush_if;
    } stall_ctrl_t;

    // Control while the memory side is not stalling: a load-use hazard
    // holds PC/IF-ID and bubbles ID/EX; otherwise the pipe advances and
    // a taken branch may squash the fetched instruction.
    function automatic stall_ctrl_t run_ctrl(input logic lu, input logic branch_flush);
        stall_ctrl_t c;
        c = '0;
        if (lu) begin
            c.dbubble = 1'b1;
        end else begin
            c.wpcir    = 1'b1;
            c.flush_if = branch_flush;
        end
        return c;
    endfunction

    // The error indication covers both ERROR and the unused code 3.
    function automatic logic is_error(input logic [1:0] st);
        return st[1];
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle of decode/EX/MEM hazard inputs and pipeline control outputs
// exchanged between the pipeline datapath (master) and the stall
// controller (slave).
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             use_rs;
    logic             use_rt;
    logic [4:0]       ern;
    logic             ewreg;
    logic             em2reg;
    logic [1:0]       pcsource;
    logic             mmem_req;
    logic             mem_ack;
    logic             wpcir;
    logic             dbubble;
    logic             freeze;
    logic             flush_if;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs, rt, use_rs, use_rt, ern, ewreg, em2reg, pcsource,
               mmem_req, mem_ack,
        input  wpcir, dbubble, freeze, flush_if, mem_err, state, stall_cnt
    );

    modport slave (
        input  rs, rt, use_rs, use_rt, ern, ewreg, em2reg, pcsource,
               mmem_req, mem_ack,
        output wpcir, dbubble, freeze, flush_if, mem_err, state, stall_cnt
    );

endinterface

// File: rtl/pipe_stall_ctrl_lu_detect.sv
// Load-use hazard comparator: the EX-stage load writes a nonzero
// register that the decode-stage instruction reads.
module pipe_lu_detect (
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [4:0] ern,
    input  logic       ewreg,
    input  logic       em2reg,
    output logic       lu
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        lu = ewreg & em2reg & (ern != 5'd0) &
             ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: arbitrates data-memory wait states,
// load-use bubbles and branch flushes, with a memory timeout that
// parks the pipe in ERROR until reset.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int DELAY_SLOT = 1,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int               WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [CNT_W-1:0]  stall_q;
    logic              lu;
    logic              ms;
    logic              branch_flush;
    stall_ctrl_t       ctrl;

    pipe_lu_detect u_lu (
        .rs     (bus.rs),
        .rt     (bus.rt),
        .use_rs (bus.use_rs),
        .use_rt (bus.use_rt),
        .ern    (bus.ern),
        .ewreg  (bus.ewreg),
        .em2reg (bus.em2reg),
        .lu     (lu)
    );

    assign ms           = bus.mmem_req & ~bus.mem_ack;
    assign branch_flush = (DELAY_SLOT == 0) && (bus.pcsource != 2'b00);

    // Next-state and control decode; memory stall beats load-use, which beats
    // branch flush, and reset forces NOP injection with no freeze.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctrl    = '0;
        if (reset) begin
            ctrl.wpcir    = 1'b1;
            ctrl.dbubble  = 1'b1;
            ctrl.flush_if = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ms) begin
                        ctrl.freeze = 1'b1;
                        state_d     = ST_MEMWAIT;
                        wait_d      = WAIT_W'(1);
                    end else begin
                        ctrl = run_ctrl(lu, branch_flush);
                    end
                end
                ST_MEMWAIT: begin
                    if (bus.mem_ack) begin
                        ctrl    = run_ctrl(lu, branch_flush);
                        state_d = ST_RUN;
                        wait_d  = '0;
                    end else begin
                        ctrl.freeze = 1'b1;
                        if (wait_q >= WAIT_LIMIT) begin
                            state_d = ST_ERROR;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
                default: begin
                    ctrl.freeze = 1'b1;
                end
            endcase
        end
    end

    // State, wait counter and saturating stall counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (!ctrl.wpcir && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.wpcir     = ctrl.wpcir;
    assign bus.dbubble   = ctrl.dbubble;
    assign bus.freeze    = ctrl.freeze;
    assign bus.flush_if  = ctrl.flush_if;
    assign bus.mem_err   = is_error(state_q);
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl. Two instances share stimulus:
// A has no delay slot and a short timeout, B keeps the delay slot and a
// 2-bit stall counter so saturation shows up quickly.
module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    logic clock;
    logic reset;
    int   testCount = 0;
    int   failCount = 0;

    pipe_stall_ctrl_if #(.CNT_W(16)) busA ();
    pipe_stall_ctrl_if #(.CNT_W(2))  busB ();

    pipe_stall_ctrl #(.DELAY_SLOT(0), .TIMEOUT(4), .CNT_W(16)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    pipe_stall_ctrl #(.DELAY_SLOT(1), .TIMEOUT(255), .CNT_W(2)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive the same decode/EX/MEM inputs onto both instances, then let
    // the combinational outputs settle.
    task automatic applyStimulus(input int rs, input int rt, input int use_rs,
                                 input int use_rt, input int ern, input int ewreg,
                                 input int em2reg, input int pcsource,
                                 input int mmem_req, input int mem_ack);
        busA.rs = 5'(rs);           busB.rs = 5'(rs);
        busA.rt = 5'(rt);           busB.rt = 5'(rt);
        busA.use_rs = 1'(use_rs);   busB.use_rs = 1'(use_rs);
        busA.use_rt = 1'(use_rt);   busB.use_rt = 1'(use_rt);
        busA.ern = 5'(ern);         busB.ern = 5'(ern);
        busA.ewreg = 1'(ewreg);     busB.ewreg = 1'(ewreg);
        busA.em2reg = 1'(em2reg);   busB.em2reg = 1'(em2reg);
        busA.pcsource = 2'(pcsource); busB.pcsource = 2'(pcsource);
        busA.mmem_req = 1'(mmem_req); busB.mmem_req = 1'(mmem_req);
        busA.mem_ack = 1'(mem_ack); busB.mem_ack = 1'(mem_ack);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset behaviour
        reset = 1'b1;
        idle();
        checkOutput("rst_wpcir",   32'(busA.wpcir), 1);
        checkOutput("rst_freeze",  32'(busA.freeze), 0);
        checkOutput("rst_dbubble", 32'(busA.dbubble), 1);
        checkOutput("rst_flush",   32'(busA.flush_if), 1);
        checkOutput("rst_flush_B", 32'(busB.flush_if), 1);
        tick();
        checkOutput("rst_state",   32'(busA.state), 32'(ST_RUN));
        checkOutput("rst_cnt",     32'(busA.stall_cnt), 0);
        checkOutput("rst_memerr",  32'(busA.mem_err), 0);
        reset = 1'b0;
        idle();
        checkOutput("idle_wpcir",  32'(busA.wpcir), 1);
        checkOutput("idle_dbub",   32'(busA.dbubble), 0);
        checkOutput("idle_flush",  32'(busA.flush_if), 0);

        // Load-use on rs
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        checkOutput("lu_wpcir",   32'(busA.wpcir), 0);
        checkOutput("lu_dbubble", 32'(busA.dbubble), 1);
        checkOutput("lu_freeze",  32'(busA.freeze), 0);
        tick();
        idle();
        checkOutput("lu_cnt",     32'(busA.stall_cnt), 1);
        checkOutput("lu_after",   32'(busA.wpcir), 1);

        // Load to r0 never stalls
        applyStimulus(0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
        checkOutput("lu0_wpcir", 32'(busA.wpcir), 1);
        checkOutput("lu0_dbub",  32'(busA.dbubble), 0);
        tick();
        idle();
        checkOutput("lu0_cnt",   32'(busA.stall_cnt), 1);

        // Load-use on rt, then rt match without use_rt, then non-load
        applyStimulus(3, 9, 0, 1, 9, 1, 1, 0, 0, 0);
        checkOutput("lurt_wpcir", 32'(busA.wpcir), 0);
        tick();
        applyStimulus(3, 9, 0, 0, 9, 1, 1, 0, 0, 0);
        checkOutput("nouse_wpcir", 32'(busA.wpcir), 1);
        applyStimulus(9, 0, 1, 0, 9, 1, 0, 0, 0, 0);
        checkOutput("noload_wpcir", 32'(busA.wpcir), 1);
        tick();
        checkOutput("lurt_cnt", 32'(busA.stall_cnt), 2);

        // Memory wait: ack low three cycles, then high
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("stray_ack_freeze", 32'(busA.freeze), 0);
        tick();
        checkOutput("stray_ack_state", 32'(busA.state), 32'(ST_RUN));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("mw1_freeze", 32'(busA.freeze), 1);
        checkOutput("mw1_wpcir",  32'(busA.wpcir), 0);
        tick();
        checkOutput("mw2_state",  32'(busA.state), 32'(ST_MEMWAIT));
        checkOutput("mw2_freeze", 32'(busA.freeze), 1);
        tick();
        checkOutput("mw3_freeze", 32'(busA.freeze), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("mwack_freeze", 32'(busA.freeze), 0);
        checkOutput("mwack_wpcir",  32'(busA.wpcir), 1);
        tick();
        idle();
        checkOutput("mw_state", 32'(busA.state), 32'(ST_RUN));
        checkOutput("mw_cnt",   32'(busA.stall_cnt), 3);
        checkOutput("mw_cnt_B", 32'(busB.stall_cnt), 3);

        // Memory stall and load-use together, then bubble after ack
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 0, 1, 0);
        checkOutput("sim_freeze", 32'(busA.freeze), 1);
        checkOutput("sim_dbub",   32'(busA.dbubble), 0);
        tick();
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 0, 1, 1);
        checkOutput("simack_freeze", 32'(busA.freeze), 0);
        checkOutput("simack_dbub",   32'(busA.dbubble), 1);
        checkOutput("simack_wpcir",  32'(busA.wpcir), 0);
        tick();
        idle();
        checkOutput("sim_state", 32'(busA.state), 32'(ST_RUN));
        checkOutput("sim_dbub_done", 32'(busA.dbubble), 0);
        checkOutput("sim_cnt",   32'(busA.stall_cnt), 5);
        checkOutput("sat_cnt_B", 32'(busB.stall_cnt), 3);

        // Branch flush depends on delay slot and yields to load-use
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        checkOutput("br_flush_A", 32'(busA.flush_if), 1);
        checkOutput("br_flush_B", 32'(busB.flush_if), 0);
        tick();
        idle();
        checkOutput("br_done", 32'(busA.flush_if), 0);
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 2, 0, 0);
        checkOutput("brlu_flush", 32'(busA.flush_if), 0);
        checkOutput("brlu_dbub",  32'(busA.dbubble), 1);
        tick();

        // Timeout: four MEMWAIT cycles without ack lands in ERROR
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("to_pre_state", 32'(busA.state), 32'(ST_MEMWAIT));
        tick();
        checkOutput("to_state",   32'(busA.state), 32'(ST_ERROR));
        checkOutput("to_memerr",  32'(busA.mem_err), 1);
        checkOutput("to_state_B", 32'(busB.state), 32'(ST_MEMWAIT));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        checkOutput("err_freeze", 32'(busA.freeze), 1);
        checkOutput("err_wpcir",  32'(busA.wpcir), 0);
        checkOutput("err_flush",  32'(busA.flush_if), 0);
        tick();
        checkOutput("err_hold", 32'(busA.state), 32'(ST_ERROR));
        doReset();
        idle();
        checkOutput("err_rst_state",  32'(busA.state), 32'(ST_RUN));
        checkOutput("err_rst_memerr", 32'(busA.mem_err), 0);

        // Ack arriving on the fourth MEMWAIT cycle wins over timeout
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("ack4_freeze", 32'(busA.freeze), 0);
        tick();
        idle();
        checkOutput("ack4_state",  32'(busA.state), 32'(ST_RUN));
        checkOutput("ack4_memerr", 32'(busA.mem_err), 0);

        // Reset in the middle of MEMWAIT abandons the access
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        checkOutput("rmw_state", 32'(busA.state), 32'(ST_MEMWAIT));
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("rmw_freeze", 32'(busA.freeze), 0);
        checkOutput("rmw_wpcir",  32'(busA.wpcir), 1);
        tick();
        reset = 1'b0;
        idle();
        checkOutput("rmw_post_state",  32'(busA.state), 32'(ST_RUN));
        checkOutput("rmw_post_cnt",    32'(busA.stall_cnt), 0);
        checkOutput("rmw_post_freeze", 32'(busA.freeze), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DELAY_SLOT, 1: 1 = branch delay slot executes; 0 = slot annulled.
- TIMEOUT, 255: maximum MEMWAIT cycles before error.
- CNT_W, 16: stall counter width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- rs  in  5  decode source register A.
- rt  in  5  decode source register B.
- use_rs  in  1  decode instruction reads rs.
- use_rt  in  1  decode instruction reads rt.
- ern  in  5  EX-stage destination.
- ewreg  in  1  EX writes register.
- em2reg  in  1  EX instruction is a load.
- pcsource  in  2  decode next-PC select; nonzero = taken branch/jump.
- mmem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ack  in  1  data memory completes access this cycle.
- wpcir  out  1  PC and IF/ID write enable.
- dbubble  out  1  ID/EX loads NOP (dwreg=dwmem=0).
- freeze  out  1  ID/EX, EX/MEM, MEM/WB hold.
- flush_if  out  1  IF/ID loads NOP.
- mem_err  out  1  sticky memory timeout flag.
- state  out  2  current FSM state.
- stall_cnt  out  CNT_W  saturating count of cycles with wpcir=0.

Function
REQ-003 States SHALL be RUN=0, MEMWAIT=1, ERROR=2; 3 unused, decodes as ERROR.
REQ-004 Load-use hazard lu SHALL be ewreg & em2reg & (ern!=0) & ((use_rs & ern==rs) | (use_rt & ern==rt)), combinational.
REQ-005 Memory stall ms SHALL be mmem_req & ~mem_ack.
REQ-006 RUN with ms=1: outputs freeze=1, wpcir=0, dbubble=0, flush_if=0; next state MEMWAIT; wait counter loads 1.
REQ-007 RUN with ms=0 and lu=1: outputs wpcir=0, dbubble=1, freeze=0, flush_if=0; state stays RUN; this is one cycle only.
REQ-008 RUN with ms=0 and lu=0: outputs wpcir=1, freeze=0, dbubble=0, flush_if = (DELAY_SLOT==0) & (pcsource!=0).
REQ-009 Priority SHALL be ms over lu over branch flush; flush_if SHALL never assert while wpcir=0.
REQ-010 MEMWAIT with mem_ack=0: freeze=1, wpcir=0; wait counter increments; when counter reaches TIMEOUT, next state is ERROR.
REQ-011 MEMWAIT with mem_ack=1: freeze=0; outputs follow REQ-007/REQ-008 for current lu/pcsource; next state RUN; wait counter clears.
REQ-012 mem_ack=1 on the same cycle as the counter reaching TIMEOUT SHALL take precedence, giving RUN.
REQ-013 ERROR: freeze=1, wpcir=0, dbubble=0, flush_if=0, mem_err=1; exits only via reset.
REQ-014 stall_cnt SHALL increment on every cycle with wpcir=0 and reset=0, holding at 2^CNT_W-1.
REQ-015 mem_ack in RUN without mmem_req SHALL be ignored.

Reset
REQ-016 While reset=1: wpcir=1, freeze=0, dbubble=1, flush_if=1, so NOPs are injected.
REQ-017 The next edge with reset=1 SHALL set state=RUN, wait counter=0, stall_cnt=0, mem_err=0.
REQ-018 Reset in MEMWAIT or ERROR SHALL abandon the access with no further freeze.

Structure
REQ-019 State encodings (RUN/MEMWAIT/ERROR) SHALL live in the shared pipeline package, used by pipeid integration and bench.
REQ-020 The hazard comparator of REQ-004 SHALL be one sub-module, pipe_lu_detect; all other logic is flat.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Load-use: ern=5, ewreg=1, em2reg=1, rs=5, use_rs=1 -> one cycle wpcir=0, dbubble=1, stall_cnt=1. Same with ern=0 -> no stall.
- Memory wait: mmem_req=1, mem_ack low 3 cycles then high -> freeze=1 for 3 cycles, state 1 then 0, stall_cnt=3.
- Simultaneous: ms=1 and lu=1 -> freeze=1, dbubble=0. After ack with lu still 1 -> one bubble cycle.
- Branch: DELAY_SLOT=0, pcsource=2, no hazard -> flush_if=1 for one cycle. DELAY_SLOT=1 -> flush_if=0. With lu=1 -> flush_if=0.
- Timeout: TIMEOUT=4, mem_ack held 0 -> state=2, mem_err=1 after 4 MEMWAIT cycles. Ack on the 4th cycle -> RUN.
- Reset mid-MEMWAIT -> next cycle state=0, stall_cnt=0, freeze=0. stall_cnt with CNT_W=2 saturates at 3.
